// File: rtl/key_pio_pkg.sv
// Register map and service FSM encoding for the push-button PIO.
package key_pio_pkg;

    localparam logic [1:0] KEY_REG_DATA = 2'd0;
    localparam logic [1:0] KEY_REG_MASK = 2'd2;
    localparam logic [1:0] KEY_REG_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_CLR     = 3'd4,
        ST_EMIT    = 3'd5
    } key_svc_state_t;

endpackage

// File: rtl/key_irq_servicer.sv
// Avalon-MM master servicing the key PIO: programs mask, reads and clears edge capture, emits events.
// Latency: irq high in IDLE -> evt_valid 4 cycles later. Optional periodic polling: KEY_IRQ_SERVICER_POLL_EN.
// Backpressure: evt_valid/evt_keys hold until evt_ready; irq is ignored until the event is accepted.
module key_irq_servicer
    import key_pio_pkg::*;
#(
    parameter int                KEY_W       = 4,
    parameter logic [KEY_W-1:0]  IRQ_MASK    = {KEY_W{1'b1}},
    parameter int unsigned       POLL_PERIOD = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              irq,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              evt_valid,
    output logic [KEY_W-1:0]  evt_keys,
    input  logic              evt_ready,
    output logic [15:0]       evt_count,
    output logic              busy
);

    if (POLL_PERIOD == 0) begin : g_poll_chk
        $error("POLL_PERIOD must be non-zero");
    end

    key_svc_state_t state, state_nxt;
    logic           svc_start;

    logic        bus_cs_nxt;
    logic        bus_wn_nxt;
    logic [1:0]  bus_addr_nxt;
    logic [31:0] bus_wd_nxt;

    logic unused_rd_hi;
    assign unused_rd_hi = ^avm_readdata[31:KEY_W];

`ifdef KEY_IRQ_SERVICER_POLL_EN
    logic [31:0] poll_cnt;

    // Reload on every IDLE entry so a poll never fires right after a service.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= 32'(POLL_PERIOD - 1);
        end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            poll_cnt <= 32'(POLL_PERIOD - 1);
        end else if (state == ST_IDLE && poll_cnt != 32'd0) begin
            poll_cnt <= poll_cnt - 32'd1;
        end
    end

    assign svc_start = irq || (poll_cnt == 32'd0);
`else
    assign svc_start = irq;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    state_nxt = ST_IDLE;
            ST_IDLE:    if (svc_start) state_nxt = ST_RD;
            ST_RD:      state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_CLR;
            ST_CLR:     state_nxt = (|evt_keys) ? ST_EMIT : ST_IDLE;
            ST_EMIT:    if (evt_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    // Bus drive is decoded from the next state and registered, so it lines up with the state.
    always_comb begin
        bus_addr_nxt = KEY_REG_EDGE;
        bus_cs_nxt   = 1'b0;
        bus_wn_nxt   = 1'b1;
        bus_wd_nxt   = 32'd0;
        case (state_nxt)
            ST_INIT: begin
                bus_addr_nxt = KEY_REG_MASK;
                bus_cs_nxt   = 1'b1;
                bus_wn_nxt   = 1'b0;
                bus_wd_nxt   = 32'(IRQ_MASK);
            end
            ST_RD, ST_RD_WAIT: begin
                bus_cs_nxt   = 1'b1;
            end
            ST_CLR: begin
                bus_cs_nxt   = 1'b1;
                bus_wn_nxt   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_INIT;
            avm_address    <= KEY_REG_MASK;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= 32'(IRQ_MASK);
            evt_valid      <= 1'b0;
            evt_keys       <= '0;
            evt_count      <= 16'd0;
        end else begin
            state          <= state_nxt;
            avm_address    <= bus_addr_nxt;
            avm_chipselect <= bus_cs_nxt;
            avm_write_n    <= bus_wn_nxt;
            avm_writedata  <= bus_wd_nxt;
            evt_valid      <= (state_nxt == ST_EMIT);
            if (state == ST_RD_WAIT) begin
                evt_keys <= avm_readdata[KEY_W-1:0];
            end
            if (state == ST_EMIT && evt_ready && evt_count != 16'hFFFF) begin
                evt_count <= evt_count + 16'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: doc/key_irq_servicer.md
# key_irq_servicer

Avalon-MM initiator that owns the push-button PIO's register interface on behalf of hardware logic. It programs the PIO interrupt mask after reset, waits for the PIO interrupt, reads and clears the edge-capture register, and presents each non-empty capture to downstream logic through a valid/ready handshake. It sits between the key PIO slave and hardware consumers such as mode FSMs or debug counters, so they need no Nios II software.

## Interface
- `KEY_W`, 4, number of key bits handled; edge-capture is `readdata[KEY_W-1:0]`.
- `IRQ_MASK`, 4'hF, value written to the PIO mask register (address 2) after reset.
- `POLL_PERIOD`, 1_000_000, clock cycles between forced services; used only with the macro.
- `clk` in 1: single clock shared with the PIO slave.
- `reset_n` in 1: asynchronous, active-low reset.
- `irq` in 1: PIO interrupt, level-high.
- `avm_address` out 2: PIO register select.
- `avm_chipselect` out 1: PIO select.
- `avm_write_n` out 1: active-low write strobe.
- `avm_writedata` out 32: write data.
- `avm_readdata` in 32: PIO read data, registered inside the slave, fixed latency 1.
- `evt_valid` out 1: captured event available.
- `evt_keys` out KEY_W: captured edge bits, held stable while `evt_valid` is high.
- `evt_ready` in 1: consumer accepts the event.
- `evt_count` out 16: number of accepted events, saturating at 16'hFFFF.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: INIT, IDLE, RD, RD_WAIT, CLR, EMIT.
- INIT (entered on reset): drive `address=2`, `chipselect=1`, `write_n=0`, `writedata={28'b0,IRQ_MASK}`. Go to IDLE.
- IDLE: drive `chipselect=0`, `write_n=1`, `address=3`, `writedata=0`. If `irq=1`, go to RD.
- RD: drive `address=3`, `chipselect=1`, `write_n=1`. Go to RD_WAIT.
- RD_WAIT: hold `address=3` and `chipselect=1`. Latch `avm_readdata[KEY_W-1:0]` into `evt_keys` at the end of the cycle. Go to CLR.
- CLR: drive `address=3`, `chipselect=1`, `write_n=0`, `writedata=0`. This clears all capture bits. If the latched keys are non-zero, go to EMIT; otherwise go to IDLE (spurious interrupt, no event).
- EMIT: `evt_valid=1`. When `evt_ready=1`, increment `evt_count` (saturating) and go to IDLE.
- `irq` is ignored outside IDLE. An edge still pending in the PIO re-raises `irq` and is serviced after EMIT.
- Known loss window: an edge captured by the PIO in the RD_WAIT cycle is erased by the CLR write. This loss is accepted.
- Reset values: FSM=INIT, `evt_valid=0`, `evt_keys=0`, `evt_count=0`. Avalon outputs take the INIT drive immediately. Reset mid-transaction abandons it, and mask programming is repeated.

## Timing
- Bus outputs are registered from the FSM state, so there is no combinational path from `irq` or `avm_readdata` to outputs.
- Latency from `irq` high in IDLE to `evt_valid` high is 4 cycles (RD, RD_WAIT, CLR, then EMIT).
- `irq` falls in the cycle after CLR, because the PIO clears edge-capture at the end of CLR.
- `evt_valid` and `evt_keys` must not change until the handshake completes. Back-to-back services are separated by at least 1 IDLE cycle.
- `busy` is combinational from the state register.

## Configuration
- `KEY_IRQ_SERVICER_POLL_EN`: when defined, a 32-bit down-counter reloads to `POLL_PERIOD-1` on every entry to IDLE. If the counter reaches 0 while in IDLE, the block enters RD even with `irq=0`. This covers configurations with `IRQ_MASK=0`.
- When undefined, no counter is built and only `irq` starts a service.

## Structure
- Shared package `key_pio_pkg`:
  - register offsets `KEY_REG_DATA=0`, `KEY_REG_MASK=2`, `KEY_REG_EDGE=3`;
  - FSM state enum `key_svc_state_t`.
- Single module; no sub-module is needed. The saturating event counter is inline.

## Test plan
- Reset release: one INIT write is seen on the bus with `address=2`, `writedata=32'hF`; then the block sits in IDLE with `chipselect=0`.
- Press key 2 on the PIO model: edge-capture reads 4'h4; `evt_valid` rises 4 cycles after `irq`; `evt_keys=4'h4`; a write of 0 to address 3 is seen; `irq` drops; `evt_count=1` after `evt_ready`.
- Hold `evt_ready=0` for 20 cycles and press key 0 during EMIT: `evt_keys` stays stable; after acceptance, a second service reports 4'h1.
- Force `irq=1` with edge-capture 0: read and clear happen, no `evt_valid` is raised, and `evt_count` is unchanged.
- Assert reset in RD_WAIT: outputs return to their reset values, and the INIT mask write is repeated after release.
- With the macro defined, `IRQ_MASK=0` and `POLL_PERIOD=100`: a key press yields `evt_valid` within 104 cycles without `irq`.
